alu_decode_stage: RTL and testbench

//  Registered successor to the single-cycle ALU control decoder: full RV32I ALU op decode
//  (shifts, slt/sltu, xor, I-type arith) plus optional M-extension ops. Sits between the

---
 rtl/alu_decode_stage_if.sv | 32 +++
 rtl/alu_decode_stage.sv | 175 +++++++++++++++++
 tb/tb_alu_decode_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_stage_if.sv
// Handshake bundle for the ALU decode stage.
// The upstream side carries the decoder fields and in_valid/in_ready.
// The downstream side carries the decoded op and out_valid/out_ready.
// The stage itself takes the slave view; whoever feeds and drains it takes the master view.
interface alu_decode_stage_if;
    // Upstream request
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       funct7b0;

    // Downstream result
    logic       out_valid;
    logic       out_ready;
    logic [4:0] alu_ctrl;
    logic       is_muldiv;
    logic       illegal;

    // Producer/consumer around the stage
    modport master (
        output in_valid, alu_op, funct3, funct7b5, funct7b0, out_ready,
        input  in_ready, out_valid, alu_ctrl, is_muldiv, illegal
    );

    // The decode stage
    modport slave (
        input  in_valid, alu_op, funct3, funct7b5, funct7b0, out_ready,
        output in_ready, out_valid, alu_ctrl, is_muldiv, illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Registered RV32I (+ optional M) ALU control decode stage.
// This is a one-entry valid/ready buffer between the main decoder and execute.
// Single-cycle ops are presented one cycle after they are accepted.
// MUL*/DIV*/REM* ops occupy the stage for MUL_LAT/DIV_LAT cycles before they are presented.
// Illegal encodings are presented as ADD with the illegal flag set.
module alu_decode_stage #(
    parameter bit EN_M    = 1'b1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    alu_decode_stage_if.slave     bus
);

    // Occupancy counter sizing follows from the longer of the two latencies.
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    // ALU control encodings; M ops are {1'b1, 1'b0, funct3}.
    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SLL  = 5'b00011;
    localparam logic [4:0] OP_SRL  = 5'b00100;
    localparam logic [4:0] OP_SRA  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;

    localparam logic [CNT_W-1:0] LAT_MUL = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] LAT_DIV = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // EMPTY: nothing held. FULL: op presented. BUSY: M op still in its occupancy window.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [4:0]       ctrl_q;
    logic             illegal_q;

    logic [4:0]       dec_ctrl;
    logic             dec_illegal;
    logic             dec_mop;
    logic [CNT_W-1:0] dec_lat;

    logic             in_ready;
    logic             accept;
    logic             load;

    // Shared RV32I funct3 decode.
    // For R-type, funct7b5 also selects SUB over ADD; for I-type it only selects SRA over SRL.
    function automatic logic [4:0] base_op(input logic [2:0] f3, input logic f7b5,
                                           input logic r_type);
        logic [4:0] op;
        op = OP_ADD;
        case (f3)
            3'b000: op = (r_type && f7b5) ? OP_SUB : OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = f7b5 ? OP_SRA : OP_SRL;
            3'b110: op = OP_OR;
            3'b111: op = OP_AND;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // Combinational decode of the incoming op, including the legality check.
    // NOTE: every output of an always_comb gets a default first, so no path leaves one
    // unassigned and infers a latch.
    always_comb begin
        dec_ctrl    = OP_ADD;
        dec_illegal = 1'b0;
        unique case (bus.alu_op)
            2'b00: dec_ctrl = OP_ADD;
            2'b01: dec_ctrl = OP_SUB;
            2'b10: begin
                if (bus.funct7b5 && bus.funct7b0) begin
                    dec_illegal = 1'b1;
                end else if (bus.funct7b0) begin
                    if (EN_M) dec_ctrl    = {2'b10, bus.funct3};
                    else      dec_illegal = 1'b1;
                end else if (bus.funct7b5 && (bus.funct3 != 3'b000) && (bus.funct3 != 3'b101)) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_ctrl = base_op(bus.funct3, bus.funct7b5, 1'b1);
                end
            end
            2'b11: dec_ctrl = base_op(bus.funct3, bus.funct7b5, 1'b0);
            default: dec_ctrl = OP_ADD;
        endcase
    end

    // The M flag lives in bit 4; illegal ops never carry it, so they take the single-cycle path.
    assign dec_mop = dec_ctrl[4];
    assign dec_lat = bus.funct3[2] ? LAT_DIV : LAT_MUL;

    // Next-state and occupancy counter logic; flush beats everything else.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        in_ready   = !flush && ((state == S_EMPTY) || ((state == S_FULL) && bus.out_ready));
        accept     = bus.in_valid && in_ready;

        if (flush) begin
            state_next = S_EMPTY;
            cnt_next   = '0;
        end else if (accept) begin
            load = 1'b1;
            if (dec_mop && (dec_lat != CNT_ONE)) begin
                state_next = S_BUSY;
                cnt_next   = dec_lat - CNT_ONE;
            end else begin
                state_next = S_FULL;
                cnt_next   = '0;
            end
        end else begin
            unique case (state)
                S_BUSY: begin
                    if (cnt == CNT_ONE) begin
                        state_next = S_FULL;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                S_FULL:  if (bus.out_ready) state_next = S_EMPTY;
                default: state_next = state;
            endcase
        end
    end

    // State and occupancy counter registers.
    // NOTE: sequential state uses non-blocking assignments, so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Output payload registers; they change only when an op is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= OP_ADD;
            illegal_q <= 1'b0;
        end else if (load) begin
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == S_FULL);
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.is_muldiv = ctrl_q[4];
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage.
// Decode vectors come from a table of expected encodings. Every accepted op pushes its
// expected result to a scoreboard queue, and a monitor pops and compares the queue on
// each output handshake. Hand-written sequences cover the timing corners: back-to-back
// ops, DIV occupancy, downstream stall, flush, mid-op reset, and the EN_M=0 build.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [2:0] f3;
        logic       f7b5;
        logic       f7b0;
        logic [4:0] ctrl;
        logic       ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush_nom = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    logic [5:0] mon_e;
    vec_t       vecs[$];

    alu_decode_stage_if bus();
    alu_decode_stage_if bus_nom();

    alu_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    alu_decode_stage #(.EN_M(1'b0)) dut_nom (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_nom),
        .bus   (bus_nom)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] a, input logic [2:0] f3, input logic f7b5,
                                input logic f7b0, input logic [4:0] ctrl, input logic ill);
        vec_t v;
        v.alu_op = a; v.f3 = f3; v.f7b5 = f7b5; v.f7b0 = f7b0; v.ctrl = ctrl; v.ill = ill;
        return v;
    endfunction

    // Present an op upstream and record what the stage must later emit for it.
    task automatic drive(input vec_t v);
        bus.in_valid = 1'b1;
        bus.alu_op   = v.alu_op;
        bus.funct3   = v.f3;
        bus.funct7b5 = v.f7b5;
        bus.funct7b0 = v.f7b0;
        exp_q.push_back({v.ill, v.ctrl});
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input vec_t v);
        int waited;
        waited = 0;
        drive(v);
        @(negedge clk);
        while (!bus.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("accept_in_time", {7'd0, bus.in_ready}, 8'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", {7'd0, bus.out_valid}, 8'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_alu_ctrl", {3'd0, bus.alu_ctrl}, {3'd0, mon_e[4:0]});
                check("sb_is_muldiv", {7'd0, bus.is_muldiv}, {7'd0, mon_e[4]});
                check("sb_illegal", {7'd0, bus.illegal}, {7'd0, mon_e[5]});
            end
        end
    end

    initial begin
        vec_t v_div;
        vec_t v_xor;
        vec_t v_add;
        int   drain;

        bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct3 = 3'b000;
        bus.funct7b5 = 1'b0; bus.funct7b0 = 1'b0; bus.out_ready = 1'b1;
        bus_nom.in_valid = 1'b0; bus_nom.alu_op = 2'b00; bus_nom.funct3 = 3'b000;
        bus_nom.funct7b5 = 1'b0; bus_nom.funct7b0 = 1'b0; bus_nom.out_ready = 1'b1;

        //        alu_op f3      f7b5  f7b0  ctrl       ill
        vecs.push_back(mk(2'b00, 3'b000, 1'b0, 1'b0, 5'b00010, 1'b0)); // load/store ADD
        vecs.push_back(mk(2'b01, 3'b000, 1'b0, 1'b0, 5'b00110, 1'b0)); // branch SUB
        vecs.push_back(mk(2'b10, 3'b000, 1'b0, 1'b0, 5'b00010, 1'b0)); // ADD
        vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b0, 5'b00110, 1'b0)); // SUB
        vecs.push_back(mk(2'b10, 3'b001, 1'b0, 1'b0, 5'b00011, 1'b0)); // SLL
        vecs.push_back(mk(2'b10, 3'b010, 1'b0, 1'b0, 5'b01000, 1'b0)); // SLT
        vecs.push_back(mk(2'b10, 3'b011, 1'b0, 1'b0, 5'b01001, 1'b0)); // SLTU
        vecs.push_back(mk(2'b10, 3'b100, 1'b0, 1'b0, 5'b00111, 1'b0)); // XOR
        vecs.push_back(mk(2'b10, 3'b101, 1'b0, 1'b0, 5'b00100, 1'b0)); // SRL
        vecs.push_back(mk(2'b10, 3'b101, 1'b1, 1'b0, 5'b00101, 1'b0)); // SRA
        vecs.push_back(mk(2'b10, 3'b110, 1'b0, 1'b0, 5'b00001, 1'b0)); // OR
        vecs.push_back(mk(2'b10, 3'b111, 1'b0, 1'b0, 5'b00000, 1'b0)); // AND
        vecs.push_back(mk(2'b11, 3'b000, 1'b1, 1'b0, 5'b00010, 1'b0)); // ADDI ignores f7b5
        vecs.push_back(mk(2'b11, 3'b101, 1'b1, 1'b1, 5'b00101, 1'b0)); // SRAI ignores f7b0
        vecs.push_back(mk(2'b11, 3'b011, 1'b0, 1'b0, 5'b01001, 1'b0)); // SLTIU
        vecs.push_back(mk(2'b10, 3'b000, 1'b0, 1'b1, 5'b10000, 1'b0)); // MUL
        vecs.push_back(mk(2'b10, 3'b011, 1'b0, 1'b1, 5'b10011, 1'b0)); // MULHU
        vecs.push_back(mk(2'b10, 3'b111, 1'b0, 1'b1, 5'b10111, 1'b0)); // REMU
        vecs.push_back(mk(2'b10, 3'b110, 1'b1, 1'b0, 5'b00010, 1'b1)); // f7b5 on OR
        vecs.push_back(mk(2'b10, 3'b000, 1'b1, 1'b1, 5'b00010, 1'b1)); // f7b5 & f7b0
        vecs.push_back(mk(2'b10, 3'b001, 1'b1, 1'b0, 5'b00010, 1'b1)); // f7b5 on SLL
        vecs.push_back(mk(2'b00, 3'b111, 1'b1, 1'b1, 5'b00010, 1'b0)); // fields ignored

        // Reset values
        #12;
        check("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check("rst_alu_ctrl", {3'd0, bus.alu_ctrl}, 8'h02);
        check("rst_illegal", {7'd0, bus.illegal}, 8'd0);
        check("rst_is_muldiv", {7'd0, bus.is_muldiv}, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        idle(2);
        @(negedge clk);
        check("post_rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("post_rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        idle(1);

        // Table-driven decode, streamed with the downstream always ready
        for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
        idle(12);

        // Back-to-back SRA then SLT
        drive(mk(2'b10, 3'b101, 1'b1, 1'b0, 5'b00101, 1'b0));
        @(negedge clk);
        check("b2b_in_ready0", {7'd0, bus.in_ready}, 8'd1);
        @(posedge clk); #1;
        drive(mk(2'b10, 3'b010, 1'b0, 1'b0, 5'b01000, 1'b0));
        @(negedge clk);
        check("b2b_in_ready1", {7'd0, bus.in_ready}, 8'd1);
        check("b2b_valid0", {7'd0, bus.out_valid}, 8'd1);
        check("b2b_ctrl_sra", {3'd0, bus.alu_ctrl}, 8'h05);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid1", {7'd0, bus.out_valid}, 8'd1);
        check("b2b_ctrl_slt", {3'd0, bus.alu_ctrl}, 8'h08);
        idle(3);

        // DIV occupancy: presented exactly 8 cycles after accept
        v_div = mk(2'b10, 3'b100, 1'b0, 1'b1, 5'b10100, 1'b0);
        bus.out_ready = 1'b0;
        drive(v_div);
        @(negedge clk);
        check("div_accept_ready", {7'd0, bus.in_ready}, 8'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("div_in_ready_c%0d", k), {7'd0, bus.in_ready}, 8'd0);
            check($sformatf("div_out_valid_c%0d", k), {7'd0, bus.out_valid}, (k == 8) ? 8'd1 : 8'd0);
        end
        check("div_alu_ctrl", {3'd0, bus.alu_ctrl}, 8'h14);
        check("div_is_muldiv", {7'd0, bus.is_muldiv}, 8'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        idle(3);

        // Downstream stall holding XOR, then release with a new ADD in the same cycle
        v_xor = mk(2'b10, 3'b100, 1'b0, 1'b0, 5'b00111, 1'b0);
        v_add = mk(2'b00, 3'b000, 1'b0, 1'b0, 5'b00010, 1'b0);
        bus.out_ready = 1'b0;
        drive(v_xor);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_out_valid", {7'd0, bus.out_valid}, 8'd1);
            check("hold_in_ready", {7'd0, bus.in_ready}, 8'd0);
            check("hold_alu_ctrl", {3'd0, bus.alu_ctrl}, 8'h07);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drive(v_add);
        @(negedge clk);
        check("release_in_ready", {7'd0, bus.in_ready}, 8'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("release_out_valid", {7'd0, bus.out_valid}, 8'd1);
        check("release_alu_ctrl", {3'd0, bus.alu_ctrl}, 8'h02);
        idle(3);

        // Flush in cycle 3 of a DIV: the op never appears
        drive(v_div);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {7'd0, bus.in_ready}, 8'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("flush_empty_ready", {7'd0, bus.in_ready}, 8'd1);
        for (int k = 0; k < 10; k++) begin
            check("flush_no_valid", {7'd0, bus.out_valid}, 8'd0);
            @(negedge clk);
        end
        idle(1);

        // Asynchronous reset in the middle of a DIV
        drive(v_div);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check("midrst_alu_ctrl", {3'd0, bus.alu_ctrl}, 8'h02);
        check("midrst_is_muldiv", {7'd0, bus.is_muldiv}, 8'd0);
        exp_q.delete();
        repeat (12) @(negedge clk);
        check("midrst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        rst_n = 1'b1;
        idle(2);

        // EN_M=0 build: M encodings and bad funct7b5 are both illegal ADD
        bus_nom.in_valid = 1'b1; bus_nom.alu_op = 2'b10; bus_nom.funct3 = 3'b000;
        bus_nom.funct7b5 = 1'b0; bus_nom.funct7b0 = 1'b1;
        @(posedge clk); #1;
        bus_nom.alu_op = 2'b10; bus_nom.funct3 = 3'b110;
        bus_nom.funct7b5 = 1'b1; bus_nom.funct7b0 = 1'b0;
        @(negedge clk);
        check("nom_m_valid", {7'd0, bus_nom.out_valid}, 8'd1);
        check("nom_m_illegal", {7'd0, bus_nom.illegal}, 8'd1);
        check("nom_m_alu_ctrl", {3'd0, bus_nom.alu_ctrl}, 8'h02);
        check("nom_m_is_muldiv", {7'd0, bus_nom.is_muldiv}, 8'd0);
        @(posedge clk); #1;
        bus_nom.in_valid = 1'b0;
        @(negedge clk);
        check("nom_f7b5_valid", {7'd0, bus_nom.out_valid}, 8'd1);
        check("nom_f7b5_illegal", {7'd0, bus_nom.illegal}, 8'd1);
        check("nom_f7b5_alu_ctrl", {3'd0, bus_nom.alu_ctrl}, 8'h02);
        idle(2);

        // Every scoreboard entry must have been consumed
        drain = 0;
        while (exp_q.size() != 0 && drain < 50) begin
            @(posedge clk);
            drain++;
        end
        check("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
